// File: rtl/modular_divider_56_if.sv
// Request/response handshake bundle for modular_divider_56: operands in on the
// request side, quotient/remainder/flags out on the response side.
interface modular_divider_56_if #(
  parameter int mul_size = 56
);
  logic                    in_valid;
  logic                    in_ready;
  logic [2*mul_size-1:0]   dividend;
  logic [mul_size-1:0]     divisor;
  logic                    out_valid;
  logic                    out_ready;
  logic [mul_size-1:0]     quotient;
  logic [mul_size-1:0]     remainder;
  logic                    div_zero;
  logic                    ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, ovf
  );
endinterface

// File: rtl/modular_divider_56.sv
// Sequential restoring divider: 2*mul_size-bit product / mul_size-bit modulus.
// Define MODULAR_DIVIDER_RADIX4_EN to retire two quotient bits per RUN cycle.
module modular_divider_56 #(
  parameter int mul_size = 56
) (
  input logic               clk,
  input logic               rst,
  modular_divider_56_if.slave bus
);
`ifdef MODULAR_DIVIDER_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int CYCLES = mul_size / STEP;
  localparam int CNT_W  = $clog2(CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [mul_size-1:0] r_q, r_d;
  logic [mul_size-1:0] q_q, q_d;
  logic [mul_size-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                div_zero_q, div_zero_d;
  logic                ovf_q, ovf_d;
  logic [mul_size-1:0] hi, lo;
  logic [2*mul_size-1:0] s1, s2;

  // One restoring step; returns {R, Q}. R < divisor keeps T within mul_size+1 bits.
  function automatic logic [2*mul_size-1:0] div_step(
    input logic [mul_size-1:0] r,
    input logic [mul_size-1:0] q,
    input logic [mul_size-1:0] d
  );
    logic [mul_size:0] shifted;
    logic [mul_size:0] t;
    shifted = {r, q[mul_size-1]};
    t       = shifted - {1'b0, d};
    if (!t[mul_size]) return {t[mul_size-1:0], q[mul_size-2:0], 1'b1};
    else              return {shifted[mul_size-1:0], q[mul_size-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
    hi          = bus.dividend[2*mul_size-1:mul_size];
    lo          = bus.dividend[mul_size-1:0];
    s1          = div_step(r_q, q_q, dvs_q);
`ifdef MODULAR_DIVIDER_RADIX4_EN
    s2          = div_step(s1[2*mul_size-1:mul_size], s1[mul_size-1:0], dvs_q);
`else
    s2          = s1;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          dvs_d      = bus.divisor;
          in_ready_d = 1'b0;
          div_zero_d = 1'b0;
          ovf_d      = 1'b0;
          if (bus.divisor == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            div_zero_d  = 1'b1;
            q_d         = '1;
            r_d         = '0;
          end else if (hi >= bus.divisor) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            ovf_d       = 1'b1;
            q_d         = '1;
            r_d         = '0;
          end else begin
            state_d = RUN;
            r_d     = hi;
            q_d     = lo;
            cnt_d   = CNT_W'(CYCLES - 1);
          end
        end
      end
      RUN: begin
        r_d   = s2[2*mul_size-1:mul_size];
        q_d   = s2[mul_size-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // Result registers are cleared too, so outputs read zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    dvs_q <= dvs_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = q_q;
  assign bus.remainder = r_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_modular_divider_56.sv
// Scoreboard bench for modular_divider_56: randomized and directed divisions
// checked against a plain-arithmetic reference model.
module tb_modular_divider_56;
  localparam int W      = 56;
  localparam int PERIOD = 10;
  localparam int HALF   = 5;
`ifdef MODULAR_DIVIDER_RADIX4_EN
  localparam int LAT = 29;
`else
  localparam int LAT = 57;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
    longint       t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;
  exp_t sb[$];

  modular_divider_56_if #(.mul_size(W)) bus();

  modular_divider_56 #(.mul_size(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #HALF clk = ~clk;

  function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] qq, rr;
    e.t = 0;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.lat = 1;
    if (b == 0) begin
      e.dz = 1'b1; e.q = '1; e.r = '0;
    end else if (a[2*W-1:W] >= b) begin
      e.ov = 1'b1; e.q = '1; e.r = '0;
    end else begin
      qq = a / {{W{1'b0}}, b};
      rr = a % {{W{1'b0}}, b};
      e.q = qq[W-1:0];
      e.r = rr[W-1:0];
      e.lat = LAT;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_quotient"},  64'(bus.quotient), 64'd0);
    chk({tag, "_remainder"}, 64'(bus.remainder), 64'd0);
    chk({tag, "_div_zero"},  64'(bus.div_zero), 64'd0);
    chk({tag, "_ovf"},       64'(bus.ovf), 64'd0);
  endtask

  task automatic send(input logic [2*W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    n = 0;
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready %0b exp 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = model(a, b);
    e.t = $time;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: checks each result on its first valid cycle, then holds it stable.
  initial begin
    bit   pv;
    bit   have;
    exp_t cur;
    logic [W-1:0] hq, hr;
    logic hdz, hov;
    int lat;
    pv = 1'b0;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; have = 1'b0;
      end else if (bus.out_valid) begin
        chk("in_ready_while_valid", 64'(bus.in_ready), 64'd0);
        if (!pv) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result got q=%0h exp none", bus.quotient);
            have = 1'b0;
          end else begin
            cur = sb[0];
            have = 1'b1;
            lat = int'((longint'($time) + HALF - cur.t) / PERIOD);
            chk("latency",   64'(lat), 64'(cur.lat));
            chk("quotient",  64'(bus.quotient), 64'(cur.q));
            chk("remainder", 64'(bus.remainder), 64'(cur.r));
            chk("div_zero",  64'(bus.div_zero), 64'(cur.dz));
            chk("ovf",       64'(bus.ovf), 64'(cur.ov));
          end
          hq = bus.quotient; hr = bus.remainder; hdz = bus.div_zero; hov = bus.ovf;
        end else begin
          chk("hold_quotient",  64'(bus.quotient), 64'(hq));
          chk("hold_remainder", 64'(bus.remainder), 64'(hr));
          chk("hold_flags",     64'({bus.div_zero, bus.ovf}), 64'({hdz, hov}));
        end
        if (bus.out_ready && have) begin
          void'(sb.pop_front());
          have = 1'b0;
        end
      end
      pv = bus.out_valid && !(bus.out_ready);
    end
  end

  // Random back-pressure, changed just after the edge so the monitor sees a settled value.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    checks++; errors++;
    $display("FAIL watchdog got timeout exp completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [63:0]    t64;
    logic [W-1:0]   dv, hi, lo;
    logic [2*W-1:0] full, a;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    send(112'd100, 56'd7);
    full = ((112'd1 << 54) - 112'd1) * ((112'd1 << 54) - 112'd3);
    send(full, 56'((112'd1 << 54) - 112'd3));
    send(112'd12345, 56'd0);
    send({56'd5, 56'd0}, 56'd5);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 25; i++) begin
      t64 = {$urandom, $urandom};
      dv  = t64[W-1:0] >> $urandom_range(0, W - 1);
      t64 = {$urandom, $urandom};
      lo  = t64[W-1:0];
      t64 = {$urandom, $urandom};
      hi  = t64[W-1:0];
      case ($urandom_range(0, 7))
        0:       dv = '0;
        1:       hi = hi | dv;
        default: hi = (dv == 0) ? '0 : hi % dv;
      endcase
      send({hi, lo}, dv);
    end
    drain();

    // Back-pressure with a stray request pulse during RUN.
    rand_rdy = 1'b0;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    a = {56'h12_3456_789a, 56'hfe_dcba_9876_5432};
    send(a, 56'h00ff_ffff_ffff);
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 112'd77;
    bus.divisor  = 56'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int n = 0; n < 200 && !bus.out_valid; n++) @(negedge clk);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    send(112'd987654321, 56'd1234);
    drain();

    // Reset in the middle of RUN abandons the operation.
    send(112'd5000000000, 56'd3);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 sb.delete();
    @(negedge clk);
    chk_idle("midrun_reset");
    rst = 1'b0;
    send(112'd1000, 56'd9);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
